// File: rtl/axis_dwc_pkg.sv
// Shared widths and FSM encoding for the AXI4-Stream width converters.
// Output width must be an integer multiple of the input width.
package axis_dwc_pkg;

    localparam int C_S00_AXIS_TDATA_WIDTH = 64;
    localparam int C_M00_AXIS_TDATA_WIDTH = 512;
    localparam int NUM_OF_BEATS           = C_M00_AXIS_TDATA_WIDTH / C_S00_AXIS_TDATA_WIDTH;
    localparam int BYTES_PER_BEAT         = C_S00_AXIS_TDATA_WIDTH / 8;
    localparam int M_KEEP_WIDTH           = C_M00_AXIS_TDATA_WIDTH / 8;
    localparam int COUNT_WIDTH            = $clog2(NUM_OF_BEATS);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    localparam count_t LAST_LANE = count_t'(NUM_OF_BEATS - 1);

endpackage

// File: rtl/axis_64_to_512_packer.sv
// Packs eight 64-bit AXI4-Stream beats into one 512-bit word; an early TLAST
// closes a partial word whose unused lanes carry zero data and zero keep.
//
// state | meaning
// INIT  | first cycle after reset, input not yet accepted
// FILL  | accepting beats into the accumulator
// HOLD  | completed word parked in the accumulator, waiting for the output slot
module axis_64_to_512_packer
    import axis_dwc_pkg::*;
(
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [M_KEEP_WIDTH-1:0]           M_AXIS_TKEEP,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    state_t                              state_q, state_d;
    count_t                              count_q, count_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   acc_data_q, acc_data_d;
    logic [M_KEEP_WIDTH-1:0]             acc_keep_q, acc_keep_d;
    logic                                acc_last_q, acc_last_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [M_KEEP_WIDTH-1:0]             out_keep_q, out_keep_d;
    logic                                out_valid_q, out_valid_d;
    logic                                out_last_q, out_last_d;

    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   merged_data;
    logic [M_KEEP_WIDTH-1:0]             merged_keep;
    logic                                completing;
    logic                                slot_free;

    always_comb begin
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        merged_data[int'(count_q) * C_S00_AXIS_TDATA_WIDTH +: C_S00_AXIS_TDATA_WIDTH] = S_AXIS_TDATA;
        merged_keep[int'(count_q) * BYTES_PER_BEAT +: BYTES_PER_BEAT] = '1;
        completing = (count_q == LAST_LANE) || S_AXIS_TLAST;
        slot_free  = !out_valid_q || M_AXIS_TREADY;

        state_d     = state_q;
        count_d     = count_q;
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        acc_last_d  = acc_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // Drain first; a load in the same cycle below takes precedence.
        if (out_valid_q && M_AXIS_TREADY) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            INIT: state_d = FILL;
            FILL: begin
                if (S_AXIS_TVALID) begin
                    if (!completing) begin
                        acc_data_d = merged_data;
                        acc_keep_d = merged_keep;
                        count_d    = count_q + 1'b1;
                    end else if (slot_free) begin
                        out_data_d  = merged_data;
                        out_keep_d  = merged_keep;
                        out_last_d  = S_AXIS_TLAST;
                        out_valid_d = 1'b1;
                        acc_data_d  = '0;
                        acc_keep_d  = '0;
                        acc_last_d  = 1'b0;
                        count_d     = '0;
                    end else begin
                        acc_data_d = merged_data;
                        acc_keep_d = merged_keep;
                        acc_last_d = S_AXIS_TLAST;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (M_AXIS_TREADY) begin
                    out_data_d  = acc_data_q;
                    out_keep_d  = acc_keep_q;
                    out_last_d  = acc_last_q;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_keep_d  = '0;
                    acc_last_d  = 1'b0;
                    count_d     = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= INIT;
            count_q     <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            acc_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            acc_last_q  <= acc_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign S_AXIS_TREADY = (state_q == FILL);
    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TKEEP  = out_keep_q;
    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TLAST  = out_last_q;

endmodule

// File: tb/tb_axis_64_to_512_packer.sv
// Scoreboard bench for axis_64_to_512_packer: directed packets push expected
// words; a monitor pops and compares on every output handshake.
module tb_axis_64_to_512_packer;

    logic         aclk;
    logic         aresetn;
    logic [63:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] bt[0:7];
    int          checks;
    int          errors;
    int          stalls;

    axis_64_to_512_packer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TKEEP  (m_tkeep),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected word from the first n entries of bt[], lane i = bt[i].
    function automatic exp_t mk(input int n, input logic l);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) begin
            e.d[i*64 +: 64] = bt[i];
            e.k[i*8 +: 8]   = 8'hFF;
        end
        e.l = l;
        return e;
    endfunction

    task automatic send(input logic [63:0] d, input logic l);
        bit hs;
        int n;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        hs = 1'b0;
        n  = 0;
        while (!hs) begin
            @(negedge aclk);
            hs = s_tready;
            @(posedge aclk);
            #1;
            if (!hs) begin
                n++;
                stalls++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got no s_tready after %0d cycles expected handshake", n);
                    hs = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge aclk);
            n++;
        end
        chk("drain_queue_empty", 512'(exp_q.size()), 512'd0);
        @(posedge aclk);
        #1;
    endtask

    // Monitor: pops on handshake, checks hold-stability and TLAST gating.
    initial begin : monitor
        exp_t e;
        exp_t held;
        bit   held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_stable", {m_tdata, m_tkeep, m_tlast, m_tvalid}, {held.d, held.k, held.l, 1'b1});
                end
                held_v = 1'b0;
                if (!m_tvalid) begin
                    chk("tlast_without_tvalid", 512'(m_tlast), 512'd0);
                end else if (m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected no word", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", m_tdata, e.d);
                        chk("word_keep", 512'(m_tkeep), 512'(e.k));
                        chk("word_last", 512'(m_tlast), 512'(e.l));
                    end
                end else begin
                    held   = '{d: m_tdata, k: m_tkeep, l: m_tlast};
                    held_v = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        checks   = 0;
        errors   = 0;
        stalls   = 0;
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_tvalid", 512'(m_tvalid), 512'd0);
        chk("reset_tdata", m_tdata, 512'd0);
        chk("reset_tkeep", 512'(m_tkeep), 512'd0);
        chk("reset_tlast", 512'(m_tlast), 512'd0);
        chk("reset_s_tready", 512'(s_tready), 512'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("init_s_tready_low", 512'(s_tready), 512'd0);
        @(negedge aclk);
        chk("fill_s_tready_high", 512'(s_tready), 512'd1);
        @(posedge aclk);
        #1;

        // Full packet, beat k = 0x1111..11 * k
        for (int k = 0; k < 8; k++) bt[k] = 64'h1111_1111_1111_1111 * 64'(k);
        exp_q.push_back(mk(8, 1'b1));
        for (int k = 0; k < 8; k++) send(bt[k], k == 7);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge aclk);
        chk("latency_full", 512'(m_tvalid), 512'd1);
        drain();

        // Back-to-back 24 beats, TLAST every 8
        stalls = 0;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 8; k++) bt[k] = 64'hA000_0000_0000_0000 | 64'(w * 16 + k);
            exp_q.push_back(mk(8, 1'b1));
        end
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 8; k++) send(64'hA000_0000_0000_0000 | 64'(w * 16 + k), k == 7);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("b2b_no_stalls", 512'(stalls), 512'd0);
        drain();

        // Partial word: A,B,C with TLAST on C
        e.d = {320'd0, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        e.k = 64'h0000_0000_00FF_FFFF;
        e.l = 1'b1;
        exp_q.push_back(e);
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send(64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
        send(64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge aclk);
        chk("latency_partial", 512'(m_tvalid), 512'd1);
        drain();

        // Single-beat packet
        bt[0] = 64'h0123_4567_89AB_CDEF;
        exp_q.push_back(mk(1, 1'b1));
        send(bt[0], 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain();

        // Backpressure: 16 beats while M_AXIS_TREADY low for 20 cycles
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) bt[k] = 64'hB000_0000_0000_0000 | 64'(w * 8 + k);
            exp_q.push_back(mk(8, 1'b1));
        end
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(64'hB000_0000_0000_0000 | 64'(i), (i % 8) == 7);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            begin
                repeat (20) @(negedge aclk);
                chk("bp_hold_s_tready_low", 512'(s_tready), 512'd0);
                chk("bp_tvalid_held", 512'(m_tvalid), 512'd1);
                @(posedge aclk);
                #1 m_tready = 1'b1;
            end
        join
        drain();

        // Mid-packet reset: a stuck word plus 5 beats are discarded
        m_tready = 1'b0;
        for (int k = 0; k < 8; k++) send(64'hDEAD_0000_0000_0000 | 64'(k), 1'b0);
        for (int k = 0; k < 5; k++) send(64'hBEEF_0000_0000_0000 | 64'(k), 1'b0);
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        #1;
        chk("midrst_tvalid", 512'(m_tvalid), 512'd0);
        chk("midrst_tdata", m_tdata, 512'd0);
        chk("midrst_tkeep", 512'(m_tkeep), 512'd0);
        chk("midrst_s_tready", 512'(s_tready), 512'd0);
        m_tready = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("midrst_init_s_tready_low", 512'(s_tready), 512'd0);
        @(negedge aclk);
        chk("midrst_fill_s_tready_high", 512'(s_tready), 512'd1);
        @(posedge aclk);
        #1;
        for (int k = 0; k < 8; k++) bt[k] = 64'h5A5A_0000_0000_0000 | 64'(k + 1);
        exp_q.push_back(mk(8, 1'b1));
        for (int k = 0; k < 8; k++) send(bt[k], k == 7);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain();

        // 8 beats without TLAST, then 2 beats with TLAST
        for (int k = 0; k < 8; k++) bt[k] = 64'hC0C0_0000_0000_0000 | 64'(k);
        exp_q.push_back(mk(8, 1'b0));
        for (int k = 0; k < 8; k++) send(bt[k], 1'b0);
        bt[0] = 64'hE1E1_E1E1_E1E1_E1E1;
        bt[1] = 64'hE2E2_E2E2_E2E2_E2E2;
        e   = mk(2, 1'b1);
        e.k = 64'h0000_0000_0000_FFFF;
        exp_q.push_back(e);
        send(bt[0], 1'b0);
        send(bt[1], 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain();

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
